// File: rtl/inv_key_sched_ctrl_if.sv
// Round-key stream between the key-schedule sequencer and the inverse-cipher datapath.
// The sequencer (inv_key_sched_ctrl) may be built with INV_KS_ABORT_EN; this interface is unaffected.
interface inv_key_sched_ctrl_if;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;

  modport master (
    output rk_valid,
    output rk_data,
    output rk_round,
    output rk_last,
    input  rk_ready
  );

  modport slave (
    input  rk_valid,
    input  rk_data,
    input  rk_round,
    input  rk_last,
    output rk_ready
  );
endinterface

// File: rtl/inv_key_sched_ctrl.sv
// Decryption key-schedule sequencer: walks the AES key expansion backwards one aligned
// group per step through an external combinational inverse step, buffers the recovered
// words and streams round keys Nr..0.
// Optional feature: define INV_KS_ABORT_EN to add the abort input.
module inv_key_sched_ctrl #(
  parameter int unsigned QDEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  alg,
  input  logic [255:0]                last_key,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  inv_key_sched_ctrl_if.master        rk,
  output logic [255:0]                step_in,
  output logic [1:0]                  step_alg,
  output logic [3:0]                  step_rcon,
  input  logic [255:0]                step_out
`ifdef INV_KS_ABORT_EN
  ,
  input  logic                        abort
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e        r_state;
  logic [1:0]    r_alg;
  logic [255:0]  r_grp;
  logic [3:0]    r_steps;
  logic [3:0]    r_round;
  logic [CW-1:0] r_count;
  logic [31:0]   r_q [QDEPTH];
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_abort;
  int            w_nk;
  logic          w_valid;
  logic          w_pop;
  logic          w_last;
  logic          w_step;
  int            w_push_n;
  int            w_base;
  logic [255:0]  w_src;
  logic [31:0]   w_push_w [8];
  logic [31:0]   w_q_d [QDEPTH];
  logic [CW-1:0] w_cnt_d;

`ifdef INV_KS_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Word j of a group sits at [255-32j -: 32].
  function automatic logic [31:0] word_at(input logic [255:0] g, input int j);
    return 32'(g >> (224 - 32 * j));
  endfunction

  // Group size Nk for the latched algorithm.
  always_comb begin
    case (r_alg)
      2'b01:   w_nk = 6;
      2'b10:   w_nk = 8;
      default: w_nk = 4;
    endcase
  end

  assign w_valid = (r_state == StRun) && (r_count >= CW'(4));
  assign w_pop   = w_valid && rk.rk_ready;
  assign w_last  = w_valid && (r_round == 4'd0);
  // Space is judged before this cycle's pop, so a step never overruns the queue.
  assign w_step  = (r_state == StRun) && (r_steps != 4'd0) &&
                   ((int'(QDEPTH) - int'(r_count)) >= w_nk);

  // Queue next state: shift out a popped key, then append pushed words behind the survivors.
  always_comb begin
    w_push_n = 0;
    if (r_state == StLoad) begin
      w_push_n = 4;
    end else if (w_step) begin
      w_push_n = w_nk;
    end
    w_src = (r_state == StLoad) ? r_grp : step_out;
    for (int k = 0; k < 8; k++) begin
      w_push_w[k] = '0;
      if (k < w_push_n) begin
        w_push_w[k] = word_at(w_src, w_push_n - 1 - k);
      end
    end
    w_base = int'(r_count) - (w_pop ? 4 : 0);
    for (int i = 0; i < int'(QDEPTH); i++) begin
      if (w_pop) begin
        w_q_d[i] = (i + 4 < int'(QDEPTH)) ? r_q[(i + 4) % int'(QDEPTH)] : '0;
      end else begin
        w_q_d[i] = r_q[i];
      end
      for (int k = 0; k < 8; k++) begin
        if ((k < w_push_n) && (i == w_base + k)) begin
          w_q_d[i] = w_push_w[k];
        end
      end
    end
    w_cnt_d = CW'(w_base + w_push_n);
  end

  // Control FSM, group register, word queue and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_alg   <= '0;
      r_grp   <= '0;
      r_steps <= '0;
      r_round <= '0;
      r_count <= '0;
      r_q     <= '{default: '0};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_abort) begin
        r_state <= StIdle;
        r_busy  <= 1'b0;
        r_steps <= '0;
        r_count <= '0;
        r_q     <= '{default: '0};
      end else begin
        r_count <= w_cnt_d;
        r_q     <= w_q_d;
        case (r_state)
          StIdle: begin
            if (start) begin
              if (alg == 2'b11) begin
                r_err <= 1'b1;
              end else begin
                r_alg   <= alg;
                r_grp   <= last_key;
                r_busy  <= 1'b1;
                r_state <= StLoad;
                case (alg)
                  2'b01: begin
                    r_steps <= 4'd8;
                    r_round <= 4'd12;
                  end
                  2'b10: begin
                    r_steps <= 4'd7;
                    r_round <= 4'd14;
                  end
                  default: begin
                    r_steps <= 4'd10;
                    r_round <= 4'd10;
                  end
                endcase
              end
            end
          end
          StLoad: r_state <= StRun;
          StRun: begin
            if (w_step) begin
              r_grp   <= step_out;
              r_steps <= r_steps - 4'd1;
            end
            if (w_pop) begin
              if (w_last) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= StIdle;
              end else begin
                r_round <= r_round - 4'd1;
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign rk.rk_valid = w_valid;
  assign rk.rk_data  = {r_q[3], r_q[2], r_q[1], r_q[0]};
  assign rk.rk_round = r_round;
  assign rk.rk_last  = w_last;
  assign step_in     = r_grp;
  assign step_alg    = r_alg;
  assign step_rcon   = r_steps;

endmodule

// File: tb/tb_inv_key_sched_ctrl.sv
// Bench for inv_key_sched_ctrl: AES key-expansion model, combinational inverse-step model
// and a scoreboard of expected round keys.
module tb_inv_key_sched_ctrl;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   round;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   alg;
  logic [255:0] last_key;
  logic         busy;
  logic         done;
  logic         err;
  logic [255:0] step_in;
  logic [1:0]   step_alg;
  logic [3:0]   step_rcon;
  logic [255:0] step_out;
  logic         abort;

  inv_key_sched_ctrl_if rk_if ();

  inv_key_sched_ctrl #(.QDEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .alg       (alg),
    .last_key  (last_key),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rk        (rk_if),
    .step_in   (step_in),
    .step_alg  (step_alg),
    .step_rcon (step_rcon),
    .step_out  (step_out)
`ifdef INV_KS_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [31:0] exp_w [64];
  int          keys_seen;
  int          first_valid_cyc;
  logic [127:0] first_key;
  logic [127:0] final_key;
  logic [3:0]  rcon_log[$];
  logic [3:0]  last_rcon;
  bit          rand_rdy = 1'b0;
  bit          mon_en = 1'b1;
  bit          prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic [3:0]  prev_round;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- AES model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] inv;
    logic [7:0] sq;
    logic [7:0] e;
    inv = 8'h01;
    sq  = v;
    e   = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, sq);
      sq = gmul(sq, sq);
    end
    if (v == 8'h00) inv = 8'h00;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] rcon(input int i);
    logic [7:0] r;
    r = 8'h01;
    for (int n = 1; n < i; n++) r = gmul(r, 8'h02);
    return {r, 24'h0};
  endfunction

  // Previous aligned group from the current one, derived from the forward recurrence.
  function automatic logic [255:0] inv_step(input logic [255:0] g, input logic [1:0] a,
                                            input logic [3:0] s);
    logic [31:0]  cur [8];
    logic [31:0]  prv [8];
    logic [255:0] o;
    int           nk;
    nk = (a == 2'b01) ? 6 : (a == 2'b10) ? 8 : 4;
    for (int t = 0; t < 8; t++) begin
      cur[t] = g[255 - 32 * t -: 32];
      prv[t] = '0;
    end
    for (int t = nk - 1; t >= 1; t--) begin
      prv[t] = cur[t] ^ (((nk == 8) && (t == 4)) ? subword(cur[t - 1]) : cur[t - 1]);
    end
    prv[0] = cur[0] ^ subword(rotword(prv[nk - 1])) ^ rcon(int'(s));
    o = '0;
    for (int t = 0; t < nk; t++) o[255 - 32 * t -: 32] = prv[t];
    return o;
  endfunction

  assign step_out = inv_step(step_in, step_alg, step_rcon);

  task automatic build_exp(input logic [255:0] ck, input int nk);
    logic [31:0] t;
    for (int i = 0; i < 64; i++) begin
      if (i < nk) begin
        exp_w[i] = ck[255 - 32 * i -: 32];
      end else begin
        t = exp_w[i - 1];
        if (i % nk == 0) t = subword(rotword(t)) ^ rcon(i / nk);
        else if ((nk == 8) && (i % nk == 4)) t = subword(t);
        exp_w[i] = exp_w[i - nk] ^ t;
      end
    end
  endtask

  // ---------------- clocking helpers ----------------
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rk_if.rk_ready = rand_rdy ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  // Monitor: scoreboard pops, stall stability, queue bound, rcon trace.
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid", rk_if.rk_valid, 1'b1);
        check_eq("stall_data", rk_if.rk_data, prev_data);
        check_eq("stall_round", rk_if.rk_round, prev_round);
      end
      if (busy) check_eq("q_bound", dut.r_count <= 16, 1'b1);
      if (rk_if.rk_valid && (first_valid_cyc < 0)) first_valid_cyc = cyc;
      if (busy && (step_rcon != last_rcon)) begin
        rcon_log.push_back(step_rcon);
        last_rcon = step_rcon;
      end
      if (rk_if.rk_valid && rk_if.rk_ready) begin
        check_eq("sb_has_entry", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check_eq("rk_data", rk_if.rk_data, e.data);
          check_eq("rk_round", rk_if.rk_round, e.round);
          check_eq("rk_last", rk_if.rk_last, e.last);
        end
        keys_seen++;
        if (keys_seen == 1) first_key = rk_if.rk_data;
        final_key = rk_if.rk_data;
      end
      prev_stall = rk_if.rk_valid && !rk_if.rk_ready;
      prev_data  = rk_if.rk_data;
      prev_round = rk_if.rk_round;
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_valid"}, rk_if.rk_valid, 0);
    check_eq({tag, "_data"}, rk_if.rk_data, 0);
    check_eq({tag, "_round"}, rk_if.rk_round, 0);
    check_eq({tag, "_last"}, rk_if.rk_last, 0);
    check_eq({tag, "_step_in"}, step_in, 0);
    check_eq({tag, "_step_alg"}, step_alg, 0);
    check_eq({tag, "_step_rcon"}, step_rcon, 0);
  endtask

  task automatic arm(input logic [1:0] a, input logic [255:0] ck, output logic [255:0] lk);
    int   nk;
    int   base;
    exp_t e;
    nk   = (a == 2'b01) ? 6 : (a == 2'b10) ? 8 : 4;
    base = (a == 2'b01) ? 48 : (a == 2'b10) ? 56 : 40;
    build_exp(ck, nk);
    lk = '0;
    for (int j = 0; j < nk; j++) lk[255 - 32 * j -: 32] = exp_w[base + j];
    for (int r = nk + 6; r >= 0; r--) begin
      e.data  = {exp_w[4 * r], exp_w[4 * r + 1], exp_w[4 * r + 2], exp_w[4 * r + 3]};
      e.round = 4'(r);
      e.last  = (r == 0);
      sb.push_back(e);
    end
    keys_seen       = 0;
    first_valid_cyc = -1;
    rcon_log.delete();
    last_rcon = 4'hf;
  endtask

  task automatic kick(input logic [1:0] a, input logic [255:0] lk, output int t0);
    @(posedge clk);
    #1;
    start    = 1'b1;
    alg      = a;
    last_key = lk;
    t0       = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_alg(input logic [1:0] a, input logic [255:0] ck, input bit poke,
                         output int lat);
    logic [255:0] lk;
    int           t0;
    int           done_cyc;
    bit           got_done;
    arm(a, ck, lk);
    kick(a, lk, t0);
    @(negedge clk);
    check_eq("busy_after_start", busy, 1'b1);
    check_eq("step_alg", step_alg, a);
    if (poke) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      alg   = 2'b11;
      @(posedge clk);
      #1;
      start = 1'b0;
      alg   = a;
      @(negedge clk);
      check_eq("err_while_busy", err, 1'b0);
      check_eq("busy_while_busy", busy, 1'b1);
    end
    got_done = 1'b0;
    done_cyc = 0;
    for (int i = 0; (i < 300) && !got_done; i++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end
    end
    check_eq("done_seen", got_done, 1'b1);
    check_eq("first_valid_lat", first_valid_cyc - t0, 2);
    check_eq("key_count", keys_seen, (a == 2'b00) ? 11 : (a == 2'b01) ? 13 : 15);
    check_eq("sb_drained", sb.size(), 0);
    check_eq("busy_at_done", busy, 1'b0);
    @(negedge clk);
    check_eq("done_one_cycle", done, 1'b0);
    lat = got_done ? (done_cyc - t0) : -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] lk;
    int           lat;
    int           t0;
    int           dn;
    rst_n    = 1'b0;
    start    = 1'b0;
    alg      = 2'b00;
    last_key = '0;
    abort    = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // AES-128, ready held high.
    run_alg(2'b00, K128, 1'b0, lat);
    check_eq("aes128_done_lat", lat, 13);
    check_eq("aes128_first", first_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_eq("aes128_last", final_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // AES-256, ready held high.
    run_alg(2'b10, K256, 1'b0, lat);
    check_eq("aes256_last", final_key, 128'h603deb1015ca71be2b73aef0857d7781);
    check_eq("aes256_rcon_len", rcon_log.size() >= 7, 1'b1);
    for (int i = 0; (i < 7) && (i < rcon_log.size()); i++) begin
      check_eq("aes256_rcon", rcon_log[i], 7 - i);
    end

    // AES-192 with a stalling consumer and a start while busy.
    rand_rdy = 1'b1;
    run_alg(2'b01, K192, 1'b1, lat);
    rand_rdy = 1'b0;

    // Illegal algorithm.
    @(posedge clk);
    #1;
    start = 1'b1;
    alg   = 2'b11;
    @(posedge clk);
    #1;
    start = 1'b0;
    alg   = 2'b00;
    @(negedge clk);
    check_eq("err_pulse", err, 1'b1);
    check_eq("err_busy", busy, 1'b0);
    @(negedge clk);
    check_eq("err_one_cycle", err, 1'b0);
    check_eq("err_busy_after", busy, 1'b0);

    // Reset after the third AES-128 key.
    arm(2'b00, K128, lk);
    kick(2'b00, lk, t0);
    for (int i = 0; (i < 50) && (keys_seen < 3); i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("rst_key3_seen", keys_seen >= 3, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_rst");
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_alg(2'b00, K128, 1'b0, lat);
    check_eq("rerun128_first", first_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_eq("rerun128_lat", lat, 13);

`ifdef INV_KS_ABORT_EN
    // Abort after the fifth AES-256 key.
    arm(2'b10, K256, lk);
    kick(2'b10, lk, t0);
    for (int i = 0; (i < 60) && (keys_seen < 5); i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("abort_key5_seen", keys_seen >= 5, 1'b1);
    @(posedge clk);
    #1;
    abort  = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check_eq("abort_valid", rk_if.rk_valid, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check_eq("abort_no_done", dn, 0);
    sb.delete();
    mon_en = 1'b1;
    run_alg(2'b10, K256, 1'b0, lat);
    check_eq("post_abort_last", final_key, 128'h603deb1015ca71be2b73aef0857d7781);
`else
    dn = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inv_key_sched_ctrl.md
# inv_key_sched_ctrl

Sequencer for the decryption key schedule. It loads the final aligned key-expansion group for AES-128, AES-192 or AES-256. It drives the external combinational inverse key-expansion step once per group, with the correct Rcon index. It buffers the recovered words and delivers round keys Nr..0 as 128-bit words over a valid/ready stream to the inverse-cipher round datapath.

## Interface
Parameters:
- QDEPTH, 16: word-queue capacity in 32-bit words; must be ≥ 12.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- alg  in  2  algorithm select: 00 = AES-128 (Nk=4, Nr=10), 01 = AES-192 (Nk=6, Nr=12), 10 = AES-256 (Nk=8, Nr=14), 11 = illegal.
- last_key  in  256  final aligned Nk-word expansion group.
  - Word j sits at [255-32j -: 32].
  - AES-128: words 40..43. AES-192: words 48..53. AES-256: words 56..63.
  - Unused low words are ignored.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the round-0 key is accepted.
- err  out  1  one-cycle pulse when start is sampled with alg=11.
- rk_valid  out  1  round key available.
- rk_ready  in  1  consumer accepts the round key.
- rk_data  out  128  round key {W4r, W4r+1, W4r+2, W4r+3}, with W4r in the MSBs.
- rk_round  out  4  round index r of rk_data.
- rk_last  out  1  high with the r=0 key.
- step_in  out  256  current group register, fed to the inverse step.
- step_alg  out  2  latched alg.
- step_rcon  out  4  Rcon index for the current step.
- step_out  in  256  previous group, combinational from step_in/step_alg/step_rcon.
- abort  in  1  present only under INV_KS_ABORT_EN.

## Operation
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Queue count is 0.
  - Group register is 0, steps_left is 0, and rk_round is 0.
- IDLE behaviour:
  - start with alg≠11: latch alg, load the group register from last_key, set steps_left to 10/8/7 (AES-128/192/256), set the next round key to Nr, go to LOAD.
  - start with alg=11: pulse err and stay in IDLE.
- LOAD:
  - Push the kept words of the initial group, highest index first. Words with index ≥ 4(Nr+1) are discarded.
  - AES-128 keeps 43..40. AES-192 keeps 51..48. AES-256 keeps 59..56.
  - Go to RUN.
- RUN step rule:
  - step_rcon = steps_left.
  - When steps_left>0 and (QDEPTH − count) ≥ Nk:
    - capture step_out into the group register;
    - push its Nk words, highest index first;
    - decrement steps_left.
  - Otherwise, hold.
- Queue and output rules:
  - The queue front is the highest remaining word index.
  - rk_valid = (count ≥ 4) in LOAD-completed states.
  - rk_data = {q[3], q[2], q[1], q[0]}.
  - Handshake: pop 4 words when rk_valid and rk_ready. rk_round then decrements.
  - Push and pop may occur in the same cycle; count updates by +Nk−4.
- Completion:
  - rk_last = rk_valid and rk_round==0.
  - The cycle after the rk_last handshake: pulse done, drop busy, go to IDLE.
  - At that point the queue is empty and steps_left=0 by construction (44/52/60 words total).
- rk_data, rk_round and rk_valid stay stable while rk_valid is high and rk_ready is low.
- start while busy is ignored, with no err.

## Timing
- Start sampled at cycle T. LOAD occurs at T+1. The first rk_valid (r=Nr) is at T+2.
- With rk_ready held high:
  - AES-128: one key per cycle; done at T+13.
  - AES-192/256: step issue is throttled by queue space; keys still stream at one per cycle once the queue fills.
- The step path is combinational; step_out is captured at the same edge that advances steps_left.
- Reset asserted mid-operation clears everything immediately. Buffered keys are lost.

## Configuration
- INV_KS_ABORT_EN:
  - Defined: the abort port exists. abort=1 in any state flushes the queue, clears steps_left, forces rk_valid low next cycle and returns to IDLE without a done pulse. abort has priority over start and over the handshake.
  - Undefined: no port; the block runs to completion.

## Test plan
- AES-128 test, with last_key = {d014f9a8 c9ee2589 e13f0cc8 b6630ca6, 128'h0}, alg=00, rk_ready=1, and a bench step model:
  - first key d014f9a8c9ee2589e13f0cc8b6630ca6 with r=10 at T+2;
  - 11th key 2b7e151628aed2a6abf7158809cf4f3c with rk_last;
  - done at T+13.
- AES-256 test, with the FIPS-197 A.3 key 603deb10…0914dff4 and last_key from the model group 56..63, alg=10:
  - 15 keys, r=14..0;
  - the last key is 603deb1015ca71be2b73aef0857d7781;
  - step_rcon sequence is 7..1.
- AES-192 test, with the FIPS-197 A.2 key and random rk_ready (30% low):
  - 13 keys match the model;
  - count never exceeds QDEPTH;
  - outputs are stable during stalls.
- start with alg=11 → err pulse for one cycle; busy stays 0. start while busy → ignored.
- Reset after the 3rd key of AES-128 → all outputs 0 next cycle; a new start works normally.
- With INV_KS_ABORT_EN, abort after the 5th AES-256 key → rk_valid low next cycle, no done, IDLE; a new run produces a correct first key.
